// File: rtl/divider16by8_seq_if.sv
// Start/done handshake bundle shared by the sequential divider and its controller.
// Same S/PRONTO protocol as the ROM multiplier so both can be chained.
interface divider16by8_seq_if;
    logic        S;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ERRO;
    logic        BUSY;
    logic        PRONTO;

    modport master (
        output S, dividend, divisor,
        input  quotient, remainder, ERRO, BUSY, PRONTO
    );

    modport slave (
        input  S, dividend, divisor,
        output quotient, remainder, ERRO, BUSY, PRONTO
    );
endinterface

// File: rtl/divider16by8_seq.sv
// Sequential restoring divider, 16-bit / 8-bit unsigned, one quotient bit per clock.
// A zero divisor skips iteration and reports quotient=FFFF, remainder=0, ERRO=1.
module divider16by8_seq (
    input  logic                 CLK,
    input  logic                 RESET,
    divider16by8_seq_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] wq;
    logic [7:0]  yd;
    logic [8:0]  r;
    logic [3:0]  cnt;
    logic        dz;

    logic [15:0] quotient_q;
    logic [7:0]  remainder_q;
    logic        erro_q;
    logic        busy_q;
    logic        pronto_q;

    logic [9:0]  shifted;
    logic        borrow;
    logic [8:0]  t;

    // Borrow is a full-width compare so R[8] participates even though it stays 0.
    always_comb begin
        shifted = {r, wq[15]};
        borrow  = (shifted < {2'b00, yd});
        t       = shifted[8:0] - {1'b0, yd};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            wq          <= '0;
            yd          <= '0;
            r           <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            erro_q      <= 1'b0;
            busy_q      <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.S) begin
                        wq     <= bus.dividend;
                        yd     <= bus.divisor;
                        r      <= '0;
                        cnt    <= '0;
                        dz     <= 1'b0;
                        busy_q <= 1'b1;
                        erro_q <= 1'b0;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (yd == '0) begin
                        dz    <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (!borrow) begin
                        r  <= t;
                        wq <= {wq[14:0], 1'b1};
                    end else begin
                        r  <= shifted[8:0];
                        wq <= {wq[14:0], 1'b0};
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= DONE;
                end
                DONE: begin
                    if (dz) begin
                        quotient_q  <= '1;
                        remainder_q <= '0;
                        erro_q      <= 1'b1;
                    end else begin
                        quotient_q  <= wq;
                        remainder_q <= r[7:0];
                        erro_q      <= 1'b0;
                    end
                    pronto_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.ERRO      = erro_q;
    assign bus.BUSY      = busy_q;
    assign bus.PRONTO    = pronto_q;
endmodule

// File: doc/divider16by8_seq.md
# divider16by8_seq

Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It is the inverse-direction companion to the team's 8x8 ROM-based multiplier. It uses the same start/done handshake (S in, PRONTO out), so a controller can chain multiply and divide operations. A divisor of zero is flagged rather than computed.

## Interface
Parameters: none (widths fixed at 16/8).

Ports:
- CLK  in  1  rising-edge clock; all state changes on this edge.
- RESET  in  1  asynchronous, active-low reset: RESET=0 immediately forces reset state, and release is sampled on CLK.
- S  in  1  start request; sampled only in IDLE.
- dividend  in  16  unsigned dividend; sampled on the accepting edge.
- divisor  in  8  unsigned divisor; sampled on the accepting edge.
- quotient  out  16  registered quotient; holds the last result.
- remainder  out  8  registered remainder; holds the last result.
- ERRO  out  1  divide-by-zero flag for the last result.
- BUSY  out  1  high from the accepting edge until the result edge.
- PRONTO  out  1  one-cycle done pulse.

## Operation
- State machine: IDLE, CHECK, ITER, DONE. The 2-bit encoding is free.
- Internal registers:
  - Wq (16): dividend / shifting quotient.
  - Yd (8): divisor.
  - R (9): partial remainder.
  - cnt (4): iteration counter.
- IDLE:
  - If S=1: Wq<=dividend, Yd<=divisor, R<=0, cnt<=0, BUSY<=1, ERRO<=0; next state CHECK.
  - If S=0: stay in IDLE.
- CHECK:
  - If Yd==0: next state DONE with the divide-by-zero flag set.
  - Otherwise: next state ITER.
- ITER, executed once per cycle:
  - Compute t = {R[7:0], Wq[15]} − {1'b0, Yd} in 9 bits, with borrow detection.
  - If no borrow: R<=t, Wq<={Wq[14:0],1}.
  - Otherwise: R<={R[7:0],Wq[15]}, Wq<={Wq[14:0],0}.
  - cnt<=cnt+1. After the iteration with cnt==15, next state is DONE; the counter wraps to 0 and is not reused.
- DONE, normal case: quotient<=Wq, remainder<=R[7:0], ERRO<=0, PRONTO<=1, BUSY<=0; next state IDLE.
- DONE, divide by zero: quotient<=16'hFFFF, remainder<=8'h00, ERRO<=1, PRONTO<=1, BUSY<=0; next state IDLE.
- PRONTO is cleared on the next edge, so it is high for exactly one cycle.
- Arithmetic invariant: R never exceeds Yd−1 after a restore step, so R[8] is 0 at DONE. Result satisfies dividend = quotient·divisor + remainder, with remainder < divisor.
- S while BUSY=1 is ignored. No queuing; the request is lost.
- S held high continuously: a new operation is accepted on the first IDLE edge after DONE, i.e. back-to-back with one IDLE cycle in between.
- Inputs may change freely after the accepting edge.

## Timing
- Reset (RESET=0, asynchronous):
  - state=IDLE.
  - quotient=0, remainder=0, ERRO=0, BUSY=0, PRONTO=0.
  - All internal registers = 0.
- Reset mid-operation aborts immediately. There is no PRONTO and outputs return to 0.
- Accept edge k (IDLE, S=1): BUSY=1 is visible after edge k.
- Edge k+1: CHECK.
- Edges k+2 .. k+17: 16 ITER cycles.
- Edge k+18 (DONE): quotient, remainder and ERRO are valid; PRONTO=1 and BUSY=0 are visible after this edge.
- Edge k+19: PRONTO=0. Earliest next accept is at edge k+19 (state IDLE).
- Divide by zero: CHECK at k+1, DONE at edge k+2 (results and PRONTO visible after k+2), PRONTO cleared at k+3.
- Latency is 18 cycles start-to-result for normal division and 2 cycles for a zero divisor.
- The outputs quotient, remainder and ERRO change only on DONE edges or on reset.

## Test plan
- Basic: dividend=1000, divisor=7, S pulse → PRONTO at accept+18, quotient=142, remainder=6, ERRO=0.
- Extremes:
  - 65535/1 → quotient=65535, remainder=0.
  - 65535/255 → quotient=257, remainder=0.
  - 0/200 → quotient=0, remainder=0.
- Small dividend: dividend=5, divisor=9 → quotient=0, remainder=5, PRONTO at accept+18.
- Divide by zero: dividend=12345, divisor=0 → PRONTO at accept+2, quotient=16'hFFFF, remainder=0, ERRO=1.
  - A following 100/10 → quotient=10, remainder=0, ERRO=0.
- Handshake:
  - Start 1000/7, then pulse S with 50/5 at accept+5 → ignored; the result is 142 r 6, and exactly one PRONTO pulse occurs.
  - S held high → second accept occurs at accept+19.
- Reset: assert RESET=0 at accept+8 of 40000/3 between clock edges → all outputs 0 immediately, no PRONTO.
  - After release, 40000/3 → quotient=13333, remainder=1.
